awmc: RTL and testbench

// - Coin-operated automatic washing machine controller: top-level FSM sequencing fill, wash, drain, rinse and spin.
// - Drives the water inlet valve and drain pump, and reports the current stage and completion.
// - Single clock domain; sits between the front-panel/coin inputs and the valve/pump drivers.

---
 rtl/awmc_pkg.sv | 46 ++++
 rtl/awmc_stage_timer.sv | 34 +++
 rtl/awmc.sv | 134 +++++++++++++
 tb/tb_awmc.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/awmc_pkg.sv
// Shared definitions for the coin-operated washing machine controller.
//   stage_t            3-bit stage encoding as presented on the stage output
//   DEF_*_CYCLES       default dwell time of each running stage, in clocks
//   max_cycles()       longest of the five dwell times (sizes the stage timer)
//   next_run_stage()   successor of a running stage in the wash sequence
package awmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_DONE  = 3'd6
  } stage_t;

  localparam int DEF_FILL_CYCLES  = 4;
  localparam int DEF_WASH_CYCLES  = 8;
  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_RINSE_CYCLES = 6;
  localparam int DEF_SPIN_CYCLES  = 6;

  function automatic int max_cycles(input int a, input int b, input int c,
                                    input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  function automatic stage_t next_run_stage(input stage_t s);
    case (s)
      ST_FILL:  return ST_WASH;
      ST_WASH:  return ST_DRAIN;
      ST_DRAIN: return ST_RINSE;
      ST_RINSE: return ST_SPIN;
      ST_SPIN:  return ST_DONE;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/awmc_stage_timer.sv
// Stage dwell timer: loadable (clear to zero), holdable up-counter with a
// terminal-count compare against a per-stage limit.
//   clk    in   system clock
//   reset  in   asynchronous active-low reset (count -> 0)
//   clr    in   load 0 on the next edge (priority over en)
//   en     in   increment on the next edge
//   limit  in   terminal value (stage length - 1)
//   tc     out  count == limit
module awmc_stage_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/awmc.sv
// Coin-operated automatic washing machine controller. Sequences
// FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE after a credited start,
// drives the inlet valve and drain pump, and reports stage and completion.
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   c_in          in   coin sensor; a sampled 0->1 edge credits one wash
//   start         in   start request (level)
//   pause         in   1 = freeze the running cycle
//   lid           in   1 = lid closed/locked
//   stage         out  current stage code (0..6)
//   done          out  wash complete
//   input_valve   out  water inlet valve enable
//   output_drain  out  drain pump enable
module awmc
  import awmc_pkg::*;
#(
  parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
  parameter int WASH_CYCLES  = DEF_WASH_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int RINSE_CYCLES = DEF_RINSE_CYCLES,
  parameter int SPIN_CYCLES  = DEF_SPIN_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       c_in,
  input  logic       start,
  input  logic       pause,
  input  logic       lid,
  output logic [2:0] stage,
  output logic       done,
  output logic       input_valve,
  output logic       output_drain
);

  localparam int MAXC = max_cycles(FILL_CYCLES, WASH_CYCLES, DRAIN_CYCLES,
                                   RINSE_CYCLES, SPIN_CYCLES);
  localparam int TW   = $clog2(MAXC) + 1;

  stage_t        state, state_nxt;
  logic          c_q, c_q_prev, credit;
  logic          coin_edge, credit_eff, credit_clr;
  logic          frozen;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_limit;

  // Coin sensor history and credit (saturating at one wash).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q      <= 1'b0;
      c_q_prev <= 1'b0;
      credit   <= 1'b0;
    end else begin
      c_q      <= c_in;
      c_q_prev <= c_q;
      credit   <= credit_clr ? 1'b0 : credit_eff;
    end
  end

  assign coin_edge  = c_q & ~c_q_prev;
  // A coin edge in the same cycle as start already counts toward the start.
  assign credit_eff = credit | coin_edge;
  assign frozen     = pause | ~lid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    credit_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (start && lid && !pause && credit_eff) begin
          state_nxt  = ST_FILL;
          credit_clr = 1'b1;
        end
      end
      ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN: begin
        if (!frozen) begin
          if (tmr_tc) begin
            state_nxt = next_run_stage(state);
            tmr_clr   = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        tmr_clr = 1'b1;
        if (!lid) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        tmr_clr   = 1'b1;
      end
    endcase
  end

  always_comb begin
    tmr_limit = '0;
    case (state)
      ST_FILL:  tmr_limit = TW'(FILL_CYCLES  - 1);
      ST_WASH:  tmr_limit = TW'(WASH_CYCLES  - 1);
      ST_DRAIN: tmr_limit = TW'(DRAIN_CYCLES - 1);
      ST_RINSE: tmr_limit = TW'(RINSE_CYCLES - 1);
      ST_SPIN:  tmr_limit = TW'(SPIN_CYCLES  - 1);
      default:  tmr_limit = '0;
    endcase
  end

  awmc_stage_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .limit(tmr_limit),
    .tc   (tmr_tc)
  );

  assign stage        = state;
  assign done         = (state == ST_DONE);
  assign input_valve  = ((state == ST_FILL)  || (state == ST_RINSE)) && !frozen;
  assign output_drain = ((state == ST_DRAIN) || (state == ST_SPIN))  && !frozen;

endmodule

// File: tb/tb_awmc.sv
// Directed bench for awmc. The stimulus process drives inputs just after each
// rising edge and queues the hand-computed outputs expected at the following
// falling edge; the monitor pops and compares on every falling edge.
module tb_awmc;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RINSE = 3'd4;
  localparam logic [2:0] S_SPIN  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic       clk = 1'b0;
  logic       reset, c_in, start, pause, lid;
  logic [2:0] stage;
  logic       done, input_valve, output_drain;

  awmc dut (
    .clk         (clk),
    .reset       (reset),
    .c_in        (c_in),
    .start       (start),
    .pause       (pause),
    .lid         (lid),
    .stage       (stage),
    .done        (done),
    .input_valve (input_valve),
    .output_drain(output_drain)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       iv;
    logic       od;
    logic       dn;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if ({stage, input_valve, output_drain, done} !==
          {mon_e.st, mon_e.iv, mon_e.od, mon_e.dn}) begin
        n_fail++;
        $display("FAIL %s @%0t: got stage=%0d valve=%b drain=%b done=%b, want stage=%0d valve=%b drain=%b done=%b",
                 mon_e.name, $time, stage, input_valve, output_drain, done,
                 mon_e.st, mon_e.iv, mon_e.od, mon_e.dn);
      end
    end
  end

  // Queue the expectation for the coming falling edge, then move to just
  // after the next rising edge.
  task automatic cyc(input logic [2:0] st, input logic iv, input logic od,
                     input logic dn, input string name);
    exp_t e;
    e.st = st; e.iv = iv; e.od = od; e.dn = dn; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] st, input int n, input logic iv,
                     input logic od, input string name);
    for (int i = 0; i < n; i++) cyc(st, iv, od, 1'b0, name);
  endtask

  // Pulse a coin with start/lid already asserted; FILL begins after the
  // second of these two IDLE cycles.
  task automatic coin_start(input string name);
    c_in = 1'b1; start = 1'b1; lid = 1'b1; pause = 1'b0;
    cyc(S_IDLE, 0, 0, 0, name);
    c_in = 1'b0;
    cyc(S_IDLE, 0, 0, 0, name);
  endtask

  task automatic full_wash(input string tag);
    run(S_FILL,  4, 1, 0, {tag, "_fill"});
    run(S_WASH,  8, 0, 0, {tag, "_wash"});
    run(S_DRAIN, 4, 0, 1, {tag, "_drain"});
    run(S_RINSE, 6, 1, 0, {tag, "_rinse"});
    run(S_SPIN,  6, 0, 1, {tag, "_spin"});
    cyc(S_DONE, 0, 0, 1, {tag, "_done"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; c_in = 1'b0; start = 1'b0; pause = 1'b0; lid = 1'b0;
    @(posedge clk);
    #1;
    cyc(S_IDLE, 0, 0, 0, "reset_state");
    cyc(S_IDLE, 0, 0, 0, "reset_state");
    reset = 1'b1;

    // start with no credit
    start = 1'b1; lid = 1'b1;
    run(S_IDLE, 20, 0, 0, "no_coin");
    start = 1'b0;

    // baseline wash; start stays high throughout and into DONE
    coin_start("base_idle");
    full_wash("base");
    cyc(S_DONE, 0, 0, 1, "done_ignores_start");
    cyc(S_DONE, 0, 0, 1, "done_ignores_start");
    lid = 1'b0;
    cyc(S_DONE, 0, 0, 1, "done_unload");
    lid = 1'b1;
    run(S_IDLE, 3, 0, 0, "after_unload_no_credit");
    start = 1'b0;

    // pause for 10 clocks at WASH timer=3
    coin_start("pw_idle");
    run(S_FILL, 4, 1, 0, "pw_fill");
    run(S_WASH, 3, 0, 0, "pw_wash_pre");
    pause = 1'b1;
    run(S_WASH, 10, 0, 0, "pw_wash_paused");
    pause = 1'b0;
    run(S_WASH, 5, 0, 0, "pw_wash_rest");
    run(S_DRAIN, 4, 0, 1, "pw_drain");
    run(S_RINSE, 6, 1, 0, "pw_rinse");
    run(S_SPIN, 6, 0, 1, "pw_spin");
    cyc(S_DONE, 0, 0, 1, "pw_done");
    lid = 1'b0;
    cyc(S_DONE, 0, 0, 1, "pw_unload");
    lid = 1'b1;
    cyc(S_IDLE, 0, 0, 0, "pw_idle_after");
    start = 1'b0;

    // lid opened during FILL, pause during DRAIN, async reset mid-SPIN
    coin_start("lid_idle");
    run(S_FILL, 2, 1, 0, "lid_fill_pre");
    lid = 1'b0;
    run(S_FILL, 5, 0, 0, "lid_fill_open");
    lid = 1'b1;
    run(S_FILL, 2, 1, 0, "lid_fill_rest");
    run(S_WASH, 8, 0, 0, "lid_wash");
    cyc(S_DRAIN, 0, 1, 0, "lid_drain");
    pause = 1'b1;
    cyc(S_DRAIN, 0, 0, 0, "drain_paused");
    pause = 1'b0;
    run(S_DRAIN, 3, 0, 1, "lid_drain_rest");
    run(S_RINSE, 6, 1, 0, "lid_rinse");
    run(S_SPIN, 2, 0, 1, "lid_spin");
    reset = 1'b0;
    cyc(S_IDLE, 0, 0, 0, "async_reset_spin");
    cyc(S_IDLE, 0, 0, 0, "async_reset_hold");
    reset = 1'b1;
    start = 1'b1; lid = 1'b1;
    run(S_IDLE, 5, 0, 0, "reset_lost_credit");
    start = 1'b0;

    // two coins in IDLE buy exactly one wash
    c_in = 1'b1; cyc(S_IDLE, 0, 0, 0, "sat_coin");
    c_in = 1'b0; cyc(S_IDLE, 0, 0, 0, "sat_coin");
    c_in = 1'b1; cyc(S_IDLE, 0, 0, 0, "sat_coin");
    c_in = 1'b0; cyc(S_IDLE, 0, 0, 0, "sat_coin");
    start = 1'b1;
    cyc(S_IDLE, 0, 0, 0, "sat_start");
    full_wash("sat");
    lid = 1'b0;
    cyc(S_DONE, 0, 0, 1, "sat_unload");
    lid = 1'b1;
    run(S_IDLE, 5, 0, 0, "sat_second_coin_ignored");

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
